// File: rtl/apb_timeout_guard.sv
// APB watchdog stage: zero-latency pass-through that aborts a stalled
// access with PSLVERR and drains the hung peripheral transfer internally.
package apb_tg_pkg;
  typedef struct packed {
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } apb_req_t;

  typedef struct packed {
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
  } apb_resp_t;
endpackage

module apb_timeout_guard
  import apb_tg_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 16,
  parameter type req_t  = apb_req_t,
  parameter type resp_t = apb_resp_t
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  req_t        slv_req_i,
  output resp_t       slv_resp_o,
  output req_t        mst_req_o,
  input  resp_t       mst_resp_i,
  output logic        timeout_o,
  output logic        busy_o,
  output logic [15:0] err_cnt_o
);

  localparam int unsigned CW =
    (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CW-1:0] CntMax = CW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {
    PASS,
    DRAIN,
    RESETUP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  req_t          abort_req_q, abort_req_d;
  logic [15:0]   err_cnt_q, err_cnt_d;
  logic          stall;
  logic          fire;
  logic          timeout;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= PASS;
      cnt_q       <= '0;
      abort_req_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      abort_req_q <= abort_req_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    abort_req_d = abort_req_q;
    err_cnt_d   = err_cnt_q;
    mst_req_o   = slv_req_i;
    slv_resp_o  = mst_resp_i;
    timeout     = 1'b0;
    fire        = 1'b0;
    stall       = slv_req_i.psel & slv_req_i.penable
                & ~mst_resp_i.pready;

    unique case (state_q)
      PASS: begin
        fire = stall && (cnt_q == CntMax);
        if (stall && (cnt_q < CntMax)) cnt_d = cnt_q + 1'b1;
        if (fire) begin
          slv_resp_o         = '0;
          slv_resp_o.pready  = 1'b1;
          slv_resp_o.pslverr = 1'b1;
          timeout            = 1'b1;
          if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          abort_req_d        = slv_req_i;
          state_d            = DRAIN;
        end
      end
      DRAIN: begin
        // peripheral response is swallowed; upstream sees a stall
        mst_req_o  = abort_req_q;
        slv_resp_o = '0;
        if (mst_resp_i.pready) state_d = RESETUP;
      end
      RESETUP: begin
        mst_req_o.penable = 1'b0;
        slv_resp_o.pready = 1'b0;
        state_d           = PASS;
      end
      default: state_d = PASS;
    endcase

    if (rst_i) begin
      mst_req_o  = '0;
      slv_resp_o = '0;
      timeout    = 1'b0;
    end
  end

  assign timeout_o = timeout;
  assign busy_o    = (state_q != PASS);
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_apb_timeout_guard.sv
// Directed bench for apb_timeout_guard: pass-through, boundary,
// abort/drain, transfer during drain, async reset, saturation.
module tb_apb_timeout_guard;
  import apb_tg_pkg::*;

  localparam int TO = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  apb_req_t    slv_req_i;
  apb_resp_t   slv_resp_o;
  apb_req_t    mst_req_o;
  apb_resp_t   mst_resp_i;
  logic        timeout_o;
  logic        busy_o;
  logic [15:0] err_cnt_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  apb_timeout_guard #(
    .TimeoutCycles(TO)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .slv_req_i (slv_req_i),
    .slv_resp_o(slv_resp_o),
    .mst_req_o (mst_req_o),
    .mst_resp_i(mst_resp_i),
    .timeout_o (timeout_o),
    .busy_o    (busy_o),
    .err_cnt_o (err_cnt_o)
  );

  task automatic check(input string tag,
                       input logic [95:0] obs,
                       input logic [95:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    slv_req_i  = '0;
    mst_resp_i = '0;
  endtask

  task automatic setup(input logic [31:0] a,
                       input logic w,
                       input logic [31:0] d);
    slv_req_i        = '0;
    slv_req_i.paddr  = a;
    slv_req_i.psel   = 1'b1;
    slv_req_i.pwrite = w;
    slv_req_i.pwdata = d;
    slv_req_i.pstrb  = 4'hF;
  endtask

  // Called one cycle after setup; returns in the first DRAIN cycle.
  task automatic abort_access(input logic [15:0] exp_err);
    slv_req_i.penable  = 1'b1;
    mst_resp_i         = '0;
    mst_resp_i.prdata  = 32'hBAD0BAD0;
    for (int c = 1; c < TO; c++) begin
      #1;
      if (c == TO - 1) begin
        check("pre_abort_pulse", timeout_o, 0);
        check("pre_abort_ready", slv_resp_o.pready, 0);
      end
      tick();
    end
    #1;
    check("abort_ready", slv_resp_o.pready, 1);
    check("abort_slverr", slv_resp_o.pslverr, 1);
    check("abort_rdata", slv_resp_o.prdata, 0);
    check("abort_pulse", timeout_o, 1);
    tick();
    slv_req_i = '0;
    #1;
    check("drain_busy", busy_o, 1);
    check("pulse_end", timeout_o, 0);
    check("err_cnt", err_cnt_o, exp_err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    apb_req_t exp_req;

    rst_i = 1'b1;
    setup(32'h55, 1'b1, 32'h77);
    slv_req_i.penable  = 1'b1;
    mst_resp_i         = '0;
    mst_resp_i.pready  = 1'b1;
    mst_resp_i.prdata  = 32'h99;
    mst_resp_i.pslverr = 1'b1;
    #2;
    check("rst_mst_req", mst_req_o, 0);
    check("rst_slv_resp", slv_resp_o, 0);
    check("rst_pulse", timeout_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_cnt_o, 0);
    tick();
    tick();
    idle();
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();

    // fast read
    setup(32'h100, 1'b0, 32'h0);
    #1;
    check("pass_setup", mst_req_o, slv_req_i);
    tick();
    slv_req_i.penable = 1'b1;
    mst_resp_i.pready = 1'b1;
    mst_resp_i.prdata = 32'hDEADBEEF;
    #1;
    check("fast_ready", slv_resp_o.pready, 1);
    check("fast_rdata", slv_resp_o.prdata, 32'hDEADBEEF);
    check("fast_slverr", slv_resp_o.pslverr, 0);
    check("fast_pulse", timeout_o, 0);
    check("fast_busy", busy_o, 0);
    tick();
    idle();

    // ready in access cycle TO: no abort
    setup(32'h104, 1'b0, 32'h0);
    tick();
    slv_req_i.penable = 1'b1;
    mst_resp_i        = '0;
    for (int c = 1; c < TO; c++) begin
      #1;
      if (c == TO - 1) check("bnd_wait", slv_resp_o.pready, 0);
      tick();
    end
    mst_resp_i.pready = 1'b1;
    mst_resp_i.prdata = 32'h12345678;
    #1;
    check("bnd_ready", slv_resp_o.pready, 1);
    check("bnd_rdata", slv_resp_o.prdata, 32'h12345678);
    check("bnd_slverr", slv_resp_o.pslverr, 0);
    check("bnd_pulse", timeout_o, 0);
    tick();
    idle();
    #1;
    check("bnd_err", err_cnt_o, 0);
    check("bnd_busy", busy_o, 0);
    tick();

    // abort, hold for 20 access cycles, then drain
    setup(32'h200, 1'b1, 32'hA5A5A5A5);
    exp_req         = slv_req_i;
    exp_req.penable = 1'b1;
    tick();
    abort_access(16'd1);
    for (int c = TO + 1; c <= 21; c++) begin
      if (c == 21) mst_resp_i.pready = 1'b1;
      #1;
      check("drain_hold", mst_req_o, exp_req);
      check("drain_stall", slv_resp_o.pready, 0);
      tick();
    end
    mst_resp_i = '0;
    #1;
    check("resetup_busy", busy_o, 1);
    check("resetup_pen", mst_req_o.penable, 0);
    check("resetup_stall", slv_resp_o.pready, 0);
    tick();
    #1;
    check("recover_busy", busy_o, 0);
    tick();

    // new write issued while draining
    setup(32'h300, 1'b0, 32'h0);
    tick();
    abort_access(16'd2);
    setup(32'h400, 1'b1, 32'hCAFE0000);
    #1;
    check("drain_old_addr", mst_req_o.paddr, 32'h300);
    check("drain_setup_stall", slv_resp_o.pready, 0);
    tick();
    slv_req_i.penable = 1'b1;
    mst_resp_i.pready = 1'b1;
    #1;
    check("drain_acc_stall", slv_resp_o.pready, 0);
    tick();
    mst_resp_i      = '0;
    exp_req         = slv_req_i;
    exp_req.penable = 1'b0;
    #1;
    check("resetup_req", mst_req_o, exp_req);
    check("resetup_wstall", slv_resp_o.pready, 0);
    tick();
    mst_resp_i.pready = 1'b1;
    #1;
    check("wr_access", mst_req_o, slv_req_i);
    check("wr_ready", slv_resp_o.pready, 1);
    check("wr_slverr", slv_resp_o.pslverr, 0);
    check("wr_busy", busy_o, 0);
    tick();
    idle();

    // async reset while draining
    setup(32'h500, 1'b0, 32'h0);
    tick();
    abort_access(16'd3);
    #1;
    rst_i = 1'b1;
    #1;
    check("arst_psel", mst_req_o.psel, 0);
    check("arst_req", mst_req_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_err", err_cnt_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();
    setup(32'h600, 1'b0, 32'h0);
    #1;
    check("arst_pass", mst_req_o, slv_req_i);
    tick();
    idle();
    tick();

    // saturation: preload counter near the top
    force dut.err_cnt_q = 16'hFFFD;
    #1;
    release dut.err_cnt_q;
    #1;
    check("sat_preload", err_cnt_o, 16'hFFFD);
    tick();
    for (int i = 0; i < 3; i++) begin
      setup(32'h700 + 32'(i), 1'b0, 32'h0);
      tick();
      abort_access((i == 0) ? 16'hFFFE : 16'hFFFF);
      mst_resp_i.pready = 1'b1;
      tick();
      mst_resp_i = '0;
      tick();
      idle();
    end
    #1;
    check("sat_hold", err_cnt_o, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
